// File: rtl/idli_dcdq_m.sv
// idli_dcdq_m: serial instruction decoder with a decoded-instruction queue.
// Deserialises 16b instructions arriving as BEAT_W-bit beats (MSB-first),
// classifies each into predicate and instruction class, and buffers the
// decoded entries in a DEPTH-entry circular FIFO. Fetch and backend each
// have a valid/ready handshake so either side can stall independently.
//
// Ports:
//   i_dcd_gck      clock
//   i_dcd_rst      synchronous active-high reset
//   i_dcd_enc      instruction beat, MSB-first
//   i_dcd_enc_vld  beat valid
//   o_dcd_enc_rdy  beat accepted when vld && rdy
//   i_dcd_flush    drop the partial instruction and all queued entries
//   o_dcd_vld      queue head valid
//   i_dcd_rdy      backend pops the head when vld && rdy
//   o_dcd_insn     head raw instruction (0 when empty)
//   o_dcd_pred     head predicate insn[15:14] (0 when empty)
//   o_dcd_cls      head instruction class (0 when empty)
//   o_dcd_cnt      queue occupancy 0..DEPTH
module idli_dcdq_m #(
    parameter int BEAT_W = 4,
    parameter int DEPTH  = 2
) (
    input  logic              i_dcd_gck,
    input  logic              i_dcd_rst,
    input  logic [BEAT_W-1:0] i_dcd_enc,
    input  logic              i_dcd_enc_vld,
    output logic              o_dcd_enc_rdy,
    input  logic              i_dcd_flush,
    output logic              o_dcd_vld,
    input  logic              i_dcd_rdy,
    output logic [15:0]       o_dcd_insn,
    output logic [1:0]        o_dcd_pred,
    output logic [2:0]        o_dcd_cls,
    output logic [2:0]        o_dcd_cnt
);

    localparam int BEATS = 16 / BEAT_W;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        CLS_ADCS_SBBS = 3'd0,
        CLS_MEM       = 3'd1,
        CLS_ALU       = 3'd2,
        CLS_SHIFT_IN  = 3'd3,
        CLS_MEMWB     = 3'd4,
        CLS_EQ_LT     = 3'd5,
        CLS_GE_MASK   = 3'd6,
        CLS_PUTP_OUT  = 3'd7
    } cls_t;

    function automatic cls_t classify(input logic [15:0] w);
        cls_t c;
        c = CLS_ADCS_SBBS;
        case (w[13:12])
            2'b00: c = CLS_ADCS_SBBS;
            2'b11: c = CLS_MEM;
            2'b10: begin
                case (w[11:9])
                    3'b110:  c = CLS_SHIFT_IN;
                    3'b111:  c = CLS_MEMWB;
                    default: c = CLS_ALU;
                endcase
            end
            default: begin
                if (w[11])     c = CLS_PUTP_OUT;
                else if (w[8]) c = CLS_GE_MASK;
                else           c = CLS_EQ_LT;
            end
        endcase
        return c;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) return '0;
        return p + 1'b1;
    endfunction

    // Assembly state
    logic [CW-1:0] beat_cnt;
    logic [15:0]   partial;
    logic [15:0]   new_word;
    logic          last_beat;

    // Queue state
    logic [15:0]   mem_insn [DEPTH];
    logic [1:0]    mem_pred [DEPTH];
    cls_t          mem_cls  [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [2:0]    cnt;

    logic beat_acc;
    logic push;
    logic pop;

    // Beats shift in at the LSB end; after BEATS beats the first beat has
    // reached insn[15 -: BEAT_W], which matches the MSB-first beat order.
    assign new_word  = (partial << BEAT_W) | 16'(i_dcd_enc);
    assign last_beat = (beat_cnt == CW'(BEATS - 1));

    assign o_dcd_vld = (cnt != 3'd0);
    assign pop       = o_dcd_vld && i_dcd_rdy;

    // Only the final beat needs queue space; a same-cycle pop frees a slot.
    assign o_dcd_enc_rdy = !i_dcd_rst && !i_dcd_flush &&
                           (!last_beat || (cnt < 3'(DEPTH)) || pop);
    assign beat_acc      = i_dcd_enc_vld && o_dcd_enc_rdy;
    assign push          = beat_acc && last_beat;

    always_ff @(posedge i_dcd_gck) begin
        if (i_dcd_rst || i_dcd_flush) begin
            beat_cnt <= '0;
            partial  <= '0;
        end else if (beat_acc) begin
            beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            partial  <= last_beat ? '0 : new_word;
        end
    end

    always_ff @(posedge i_dcd_gck) begin
        if (i_dcd_rst || i_dcd_flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) tail <= ptr_inc(tail);
            if (pop)  head <= ptr_inc(head);
            case ({push, pop})
                2'b10:   cnt <= cnt + 3'd1;
                2'b01:   cnt <= cnt - 3'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: head outputs are masked while the queue is empty.
    always_ff @(posedge i_dcd_gck) begin
        if (push) begin
            mem_insn[tail] <= new_word;
            mem_pred[tail] <= new_word[15:14];
            mem_cls[tail]  <= classify(new_word);
        end
    end

    always_comb begin
        o_dcd_insn = '0;
        o_dcd_pred = '0;
        o_dcd_cls  = '0;
        if (o_dcd_vld) begin
            o_dcd_insn = mem_insn[head];
            o_dcd_pred = mem_pred[head];
            o_dcd_cls  = mem_cls[head];
        end
    end

    assign o_dcd_cnt = cnt;

endmodule
